rxiq_stream_ctrl: RTL and testbench

//  Sequences the RX IQ capture path between rxiq and the RX sample FIFO. Enables

---
 rtl/rxiq_stream_ctrl.sv | 164 ++++++++++++++++
 tb/tb_rxiq_stream_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/rxiq_stream_ctrl.sv
// RX IQ capture sequencer: gates rxiq, cuts its words into fixed-length timestamped packets, drops whole packets the FIFO cannot hold.
// Latency: FIFO write/sop/eop/pkt_ts 1 clk after smpl_wrreq; no backpressure to rxiq, fifo_wfull only suppresses writes and sets ovf.
module rxiq_stream_ctrl #(
  parameter int iq_width = 12,
  parameter int pkt_w    = 16,
  parameter int free_w   = 16,
  parameter int drop_w   = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  en,
  input  logic [pkt_w-1:0]      pkt_len,
  output logic                  rxiq_en,
  input  logic                  smpl_wrreq,
  input  logic [4*iq_width-1:0] smpl_wdata,
  input  logic [free_w-1:0]     fifo_wfree,
  input  logic                  fifo_wfull,
  output logic                  fifo_wrreq,
  output logic [4*iq_width-1:0] fifo_wdata,
  output logic                  fifo_sop,
  output logic                  fifo_eop,
  output logic [63:0]           pkt_ts,
  output logic [drop_w-1:0]     drop_cnt,
  output logic                  ovf,
  input  logic                  ovf_clr,
  output logic                  busy
);

  localparam int cw = (free_w > pkt_w) ? free_w : pkt_w;

  typedef enum logic [2:0] {IDLE, BOUND, PASS, DROP, FLUSH} state_t;

  state_t           state;
  logic [63:0]      smpl_cnt;
  logic [pkt_w-1:0] wcnt;
  logic [pkt_w-1:0] len;

  logic [pkt_w-1:0] len_new;
  logic             len_one;
  logic             fits;
  logic             last;
  logic             drop_ev;
  logic             sup_ev;

  always_comb begin
    len_new = (pkt_len == '0) ? pkt_w'(1) : pkt_len;
    len_one = (len_new == pkt_w'(1));
    fits    = (cw'(fifo_wfree) >= cw'(len_new)) && !fifo_wfull;
    last    = (wcnt == len - pkt_w'(1));
    drop_ev = (state == BOUND) && smpl_wrreq && !fits;
    sup_ev  = ((state == PASS) || (state == FLUSH)) && smpl_wrreq && fifo_wfull;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      smpl_cnt   <= '0;
      wcnt       <= '0;
      len        <= '0;
      rxiq_en    <= 1'b0;
      busy       <= 1'b0;
      fifo_wrreq <= 1'b0;
      fifo_wdata <= '0;
      fifo_sop   <= 1'b0;
      fifo_eop   <= 1'b0;
      pkt_ts     <= '0;
    end else begin
      fifo_wrreq <= 1'b0;
      fifo_sop   <= 1'b0;
      fifo_eop   <= 1'b0;
      // Dropped and suppressed words still advance the timestamp base.
      if (state != IDLE && smpl_wrreq)
        smpl_cnt <= smpl_cnt + 64'd1;

      case (state)
        IDLE: begin
          if (en) begin
            state    <= BOUND;
            smpl_cnt <= '0;
            rxiq_en  <= 1'b1;
            busy     <= 1'b1;
          end
        end
        BOUND: begin
          if (smpl_wrreq) begin
            len  <= len_new;
            wcnt <= pkt_w'(1);
            if (fits) begin
              fifo_wrreq <= 1'b1;
              fifo_wdata <= smpl_wdata;
              fifo_sop   <= 1'b1;
              fifo_eop   <= len_one;
              pkt_ts     <= smpl_cnt;
              state      <= len_one ? BOUND : PASS;
            end else begin
              state <= len_one ? BOUND : DROP;
            end
          end else if (!en) begin
            state   <= IDLE;
            rxiq_en <= 1'b0;
            busy    <= 1'b0;
          end
        end
        PASS, FLUSH: begin
          if (smpl_wrreq) begin
            if (!fifo_wfull) begin
              fifo_wrreq <= 1'b1;
              fifo_wdata <= smpl_wdata;
              fifo_eop   <= last;
            end
            if (last) begin
              state <= en ? BOUND : IDLE;
              if (!en) begin
                rxiq_en <= 1'b0;
                busy    <= 1'b0;
              end
            end else begin
              wcnt  <= wcnt + pkt_w'(1);
              state <= en ? PASS : FLUSH;
            end
          end else begin
            state <= en ? PASS : FLUSH;
          end
        end
        DROP: begin
          if (!en) begin
            state   <= IDLE;
            rxiq_en <= 1'b0;
            busy    <= 1'b0;
          end else if (smpl_wrreq) begin
            if (last)
              state <= BOUND;
            else
              wcnt <= wcnt + pkt_w'(1);
          end
        end
        default: begin
          state   <= IDLE;
          rxiq_en <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  // A new event in the clear cycle wins over the clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_cnt <= '0;
      ovf      <= 1'b0;
    end else begin
      if (drop_ev)
        drop_cnt <= ovf_clr ? drop_w'(1) : ((&drop_cnt) ? drop_cnt : drop_cnt + drop_w'(1));
      else if (ovf_clr)
        drop_cnt <= '0;

      if (drop_ev || sup_ev)
        ovf <= 1'b1;
      else if (ovf_clr)
        ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rxiq_stream_ctrl.sv
// Bench for rxiq_stream_ctrl: table of per-cycle stimulus with expected writes pushed to a scoreboard,
// expected status checked after the edge, plus hand sequences for async reset and drop_cnt saturation.
module tb_rxiq_stream_ctrl;

  logic        clk;
  logic        reset_n;
  logic        en;
  logic [15:0] pkt_len;
  logic        rxiq_en;
  logic        smpl_wrreq;
  logic [47:0] smpl_wdata;
  logic [15:0] fifo_wfree;
  logic        fifo_wfull;
  logic        fifo_wrreq;
  logic [47:0] fifo_wdata;
  logic        fifo_sop;
  logic        fifo_eop;
  logic [63:0] pkt_ts;
  logic [15:0] drop_cnt;
  logic        ovf;
  logic        ovf_clr;
  logic        busy;

  rxiq_stream_ctrl dut (
    .clk(clk), .reset_n(reset_n), .en(en), .pkt_len(pkt_len), .rxiq_en(rxiq_en),
    .smpl_wrreq(smpl_wrreq), .smpl_wdata(smpl_wdata), .fifo_wfree(fifo_wfree),
    .fifo_wfull(fifo_wfull), .fifo_wrreq(fifo_wrreq), .fifo_wdata(fifo_wdata),
    .fifo_sop(fifo_sop), .fifo_eop(fifo_eop), .pkt_ts(pkt_ts), .drop_cnt(drop_cnt),
    .ovf(ovf), .ovf_clr(ovf_clr), .busy(busy)
  );

  typedef struct {
    bit          en;
    bit          wr;
    logic [15:0] len;
    logic [15:0] free;
    bit          full;
    bit          clr;
    bit          ew;
    bit          es;
    bit          ee;
    logic [63:0] ts;
    bit          chk;
    bit          busy;
    bit          rxen;
    logic [15:0] drop;
    bit          ovf;
  } vec_t;

  typedef struct {
    logic [47:0] d;
    bit          sop;
    bit          eop;
    logic [63:0] ts;
    int          cyc;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Output side of the scoreboard: writes must match the queue head in order and cycle.
  always @(posedge clk) begin
    #1;
    if (fifo_wrreq) begin
      if (sb.size() == 0) begin
        chk("unexpected_write", 64'(fifo_wdata), 64'hx);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("wdata", 64'(fifo_wdata), 64'(e.d));
        chk("sop", 64'(fifo_sop), 64'(e.sop));
        chk("eop", 64'(fifo_eop), 64'(e.eop));
        chk("write_cycle", 64'(cyc), 64'(e.cyc));
        if (e.sop) chk("pkt_ts", pkt_ts, e.ts);
      end
    end else if (fifo_sop || fifo_eop) begin
      chk("sop_eop_without_wrreq", {62'd0, fifo_sop, fifo_eop}, 64'd0);
    end
  end

  task automatic add(input bit en_i, input bit wr, input int len, input int free, input bit full,
                     input bit clr, input bit ew, input bit es, input bit ee, input int ts,
                     input bit c, input bit b, input bit rx, input int drop, input bit o);
    vec_t v;
    v.en = en_i; v.wr = wr; v.len = 16'(len); v.free = 16'(free); v.full = full; v.clr = clr;
    v.ew = ew; v.es = es; v.ee = ee; v.ts = 64'(ts);
    v.chk = c; v.busy = b; v.rxen = rx; v.drop = 16'(drop); v.ovf = o;
    tbl.push_back(v);
  endtask

  task automatic run_tbl();
    foreach (tbl[i]) begin
      @(negedge clk);
      en = tbl[i].en; smpl_wrreq = tbl[i].wr; pkt_len = tbl[i].len;
      fifo_wfree = tbl[i].free; fifo_wfull = tbl[i].full; ovf_clr = tbl[i].clr;
      smpl_wdata = 48'({$urandom(), $urandom()});
      if (tbl[i].ew) begin
        exp_t e;
        e.d = smpl_wdata; e.sop = tbl[i].es; e.eop = tbl[i].ee; e.ts = tbl[i].ts; e.cyc = cyc + 1;
        sb.push_back(e);
      end
      if (tbl[i].chk) begin
        @(posedge clk);
        #2;
        chk($sformatf("busy[%0d]", i), 64'(busy), 64'(tbl[i].busy));
        chk($sformatf("rxiq_en[%0d]", i), 64'(rxiq_en), 64'(tbl[i].rxen));
        chk($sformatf("drop_cnt[%0d]", i), 64'(drop_cnt), 64'(tbl[i].drop));
        chk($sformatf("ovf[%0d]", i), 64'(ovf), 64'(tbl[i].ovf));
      end
    end
    tbl.delete();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rxiq_en"}, 64'(rxiq_en), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_wrreq"}, 64'(fifo_wrreq), 64'd0);
    chk({tag, "_wdata"}, 64'(fifo_wdata), 64'd0);
    chk({tag, "_sop_eop"}, {62'd0, fifo_sop, fifo_eop}, 64'd0);
    chk({tag, "_pkt_ts"}, pkt_ts, 64'd0);
    chk({tag, "_drop_cnt"}, 64'(drop_cnt), 64'd0);
    chk({tag, "_ovf"}, 64'(ovf), 64'd0);
  endtask

  initial begin
    reset_n = 1'b0; en = 1'b0; pkt_len = 16'd4; smpl_wrreq = 1'b0; smpl_wdata = '0;
    fifo_wfree = 16'd100; fifo_wfull = 1'b0; ovf_clr = 1'b0;
    #23;
    chk_all_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // Start, then three 4-word packets.
    add(1,0,4,100,0,0, 0,0,0,0, 1,1,1,0,0);
    for (int i = 0; i < 12; i++) add(1,1,4,100,0,0, 1,(i%4)==0,(i%4)==3,(i/4)*4, 0,0,0,0,0);
    add(0,0,4,100,0,0, 0,0,0,0, 1,0,0,0,0);
    add(1,0,4,100,0,0, 0,0,0,0, 1,1,1,0,0);
    // Packet 0 dropped for lack of room, packet 1 admitted.
    add(1,1,4,3,0,0, 0,0,0,0, 1,1,1,1,1);
    for (int i = 1; i < 4; i++) add(1,1,4,100,0,0, 0,0,0,0, 0,0,0,0,0);
    for (int i = 4; i < 8; i++) add(1,1,4,100,0,0, 1,i==4,i==7,4, i==7,1,1,1,1);
    add(1,0,4,100,0,1, 0,0,0,0, 1,1,1,0,0);
    // Full pulse on word 2 of a passing packet.
    add(1,1,4,100,0,0, 1,1,0,8, 0,0,0,0,0);
    add(1,1,4,100,0,0, 1,0,0,0, 0,0,0,0,0);
    add(1,1,4,100,1,0, 0,0,0,0, 1,1,1,0,1);
    add(1,1,4,100,0,0, 1,0,1,0, 0,0,0,0,0);
    // Two dropped packets, the second coinciding with ovf_clr.
    add(1,1,4,3,0,0, 0,0,0,0, 1,1,1,1,1);
    for (int i = 13; i < 16; i++) add(1,1,4,100,0,0, 0,0,0,0, 0,0,0,0,0);
    add(1,1,4,3,0,1, 0,0,0,0, 1,1,1,1,1);
    for (int i = 17; i < 20; i++) add(1,1,4,100,0,0, 0,0,0,0, 0,0,0,0,0);
    // Length 0 and 1 give single-word packets.
    for (int i = 20; i < 23; i++) add(1,1,0,100,0,0, 1,1,1,i, 0,0,0,0,0);
    for (int i = 23; i < 25; i++) add(1,1,1,100,0,0, 1,1,1,i, 0,0,0,0,0);
    add(1,1,0,0,0,0, 0,0,0,0, 1,1,1,2,1);
    add(1,1,1,1,0,0, 1,1,1,26, 0,0,0,0,0);
    // Free space exactly equal to the packet length is enough.
    add(1,1,4,4,0,0, 1,1,0,27, 0,0,0,0,0);
    for (int i = 28; i < 31; i++) add(1,1,4,4,0,0, 1,0,i==30,0, 0,0,0,0,0);
    // en falls after word 1: packet flushes, then idle.
    add(1,1,4,100,0,0, 1,1,0,31, 0,0,0,0,0);
    add(1,1,4,100,0,0, 1,0,0,0, 0,0,0,0,0);
    add(0,0,4,100,0,0, 0,0,0,0, 1,1,1,2,1);
    add(0,1,4,100,0,0, 1,0,0,0, 0,0,0,0,0);
    add(0,1,4,100,0,0, 1,0,1,0, 1,0,0,2,1);
    // en returns during flush: packet completes and stream continues.
    add(1,0,4,100,0,0, 0,0,0,0, 1,1,1,2,1);
    add(1,1,4,100,0,0, 1,1,0,0, 0,0,0,0,0);
    add(0,0,4,100,0,0, 0,0,0,0, 0,0,0,0,0);
    add(1,1,4,100,0,0, 1,0,0,0, 0,0,0,0,0);
    add(1,1,4,100,0,0, 1,0,0,0, 0,0,0,0,0);
    add(1,1,4,100,0,0, 1,0,1,0, 1,1,1,2,1);
    // en falls in DROP: straight to idle.
    add(1,1,4,3,0,0, 0,0,0,0, 1,1,1,3,1);
    add(0,0,4,100,0,0, 0,0,0,0, 1,0,0,3,1);
    // Mid-packet state before async reset.
    add(1,0,2,100,0,0, 0,0,0,0, 1,1,1,3,1);
    add(1,1,2,100,0,0, 1,1,0,0, 0,0,0,0,0);
    add(1,1,2,100,0,0, 1,0,1,0, 0,0,0,0,0);
    add(1,1,2,100,0,0, 1,1,0,2, 0,0,0,0,0);
    run_tbl();

    @(posedge clk);
    #3;
    smpl_wrreq = 1'b0;
    reset_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    @(negedge clk);
    reset_n = 1'b1;

    add(1,0,2,100,0,0, 0,0,0,0, 1,1,1,0,0);
    add(1,1,2,100,0,0, 1,1,0,0, 0,0,0,0,0);
    add(1,1,2,100,0,0, 1,0,1,0, 0,0,0,0,0);
    run_tbl();

    // Continuous single-word drops up to saturation.
    @(negedge clk);
    pkt_len = 16'd1; fifo_wfree = 16'd0; smpl_wrreq = 1'b1;
    for (int i = 1; i < 65535; i++) @(negedge clk);
    @(posedge clk);
    #2;
    chk("drop_cnt_at_max", 64'(drop_cnt), 64'hFFFF);
    chk("ovf_at_max", 64'(ovf), 64'd1);
    @(posedge clk);
    #2;
    chk("drop_cnt_saturated", 64'(drop_cnt), 64'hFFFF);
    @(negedge clk);
    smpl_wrreq = 1'b0; en = 1'b0;
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
